// File: rtl/irq_sequencer.sv
// Interrupt sequencer: captures rising-edge requests, masks and prioritises them, and runs the
// request/ack/end-of-interrupt handshake that steers the processor data path to i_data.
module irq_sequencer #(
  parameter int unsigned NUM_IRQ     = 8,
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic                       clk,
  input  logic                       rstN,
  input  logic [NUM_IRQ-1:0]         irq_in,
  input  logic                       int_en,
  input  logic                       mask_wr,
  input  logic [NUM_IRQ-1:0]         mask_data,
  input  logic                       irq_ack,
  input  logic                       eoi,
  input  logic                       clr_err,
  output logic                       irq_req,
  output logic [$clog2(NUM_IRQ)-1:0] irq_id,
  output logic                       data_select,
  output logic                       in_service,
  output logic [NUM_IRQ-1:0]         pending,
  output logic                       timeout_err
);

  localparam int unsigned IdW = $clog2(NUM_IRQ);
  localparam logic [7:0] CntLast = 8'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StReq, StService} state_e;

  state_e               state_q, state_d;
  logic [NUM_IRQ-1:0]   pending_q, pending_d;
  logic [NUM_IRQ-1:0]   mask_q, mask_d;
  logic [NUM_IRQ-1:0]   irq_prev_q;
  logic [7:0]           cnt_q, cnt_d;
  logic [IdW-1:0]       irq_id_q, irq_id_d;
  logic                 timeout_err_q, timeout_err_d;
  logic                 irq_req_q, data_select_q, in_service_q;
  logic [NUM_IRQ-1:0]   edges;
  logic [NUM_IRQ-1:0]   eligible;
  logic [IdW-1:0]       top_id;
  logic                 timeout;
  logic                 ack_clear;

  assign edges    = irq_in & ~irq_prev_q;
  assign eligible = pending_q & ~mask_q;

  // Ascending scan so the highest set index is the one left standing.
  always_comb begin
    top_id = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (eligible[i]) top_id = IdW'(i);
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    irq_id_d  = irq_id_q;
    timeout   = 1'b0;
    ack_clear = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (int_en && (eligible != '0)) begin
          irq_id_d = top_id;
          cnt_d    = '0;
          state_d  = StReq;
        end
      end
      StReq: begin
        if (irq_ack) begin
          ack_clear = 1'b1;
          state_d   = StService;
        end else if (!int_en) begin
          state_d = StIdle;
        end else if (cnt_q == CntLast) begin
          timeout = 1'b1;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StService: begin
        if (eoi) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // New edges are applied after the ack clear so a same-cycle set wins.
  always_comb begin
    pending_d = pending_q;
    if (ack_clear) pending_d[irq_id_q] = 1'b0;
    pending_d = pending_d | edges;
  end

  assign mask_d        = mask_wr ? mask_data : mask_q;
  assign timeout_err_d = timeout ? 1'b1 : (clr_err ? 1'b0 : timeout_err_q);

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q       <= StIdle;
      pending_q     <= '0;
      mask_q        <= '0;
      irq_prev_q    <= '0;
      cnt_q         <= '0;
      irq_id_q      <= '0;
      timeout_err_q <= 1'b0;
      irq_req_q     <= 1'b0;
      data_select_q <= 1'b0;
      in_service_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      pending_q     <= pending_d;
      mask_q        <= mask_d;
      irq_prev_q    <= irq_in;
      cnt_q         <= cnt_d;
      irq_id_q      <= irq_id_d;
      timeout_err_q <= timeout_err_d;
      irq_req_q     <= (state_d == StReq);
      data_select_q <= (state_d == StService);
      in_service_q  <= (state_d == StService);
    end
  end

  assign irq_req     = irq_req_q;
  assign irq_id      = irq_id_q;
  assign data_select = data_select_q;
  assign in_service  = in_service_q;
  assign pending     = pending_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: doc/irq_sequencer.md
# irq_sequencer

Interrupt sequencer that arbitrates eight request lines into a single serviced request for the processor datapath. It latches rising-edge requests, masks them, selects the highest priority one (bit 7 highest, matching the processor's priority-encoder ordering), and runs a request/acknowledge/end-of-interrupt handshake with the host. While a request is in service it steers the processor's `data_select` to the interrupt-data path (`i_data`). The block sits between the peripheral request lines and the processor's `data_select` input.

## Interface
- `NUM_IRQ`, 8, number of request lines; `irq_id` width is $clog2(NUM_IRQ).
- `ACK_TIMEOUT`, 15, cycles `irq_req` stays high without `irq_ack` before the request is withdrawn; legal range 2..255.

- `clk`  in  1  single clock; all logic on the rising edge.
- `rstN`  in  1  asynchronous, active-low reset.
- `irq_in`  in  NUM_IRQ  request lines, rising-edge sensitive, bit NUM_IRQ-1 highest priority.
- `int_en`  in  1  global interrupt enable.
- `mask_wr`  in  1  loads `mask_data` into the mask register (1 = masked).
- `mask_data`  in  NUM_IRQ  mask value.
- `irq_ack`  in  1  host accepts the current request.
- `eoi`  in  1  host ends service of the current request.
- `clr_err`  in  1  clears `timeout_err`.
- `irq_req`  out  1  request to host.
- `irq_id`  out  3  index of the request being offered or serviced.
- `data_select`  out  1  processor path select (0 = `data_in`, 1 = `i_data`).
- `in_service`  out  1  high while in SERVICE.
- `pending`  out  NUM_IRQ  pending register.
- `timeout_err`  out  1  sticky acknowledge-timeout flag.

## Operation
- Reset: state IDLE; `pending`, mask, `irq_prev`, timeout counter, `irq_id`, `irq_req`, `data_select`, `in_service`, `timeout_err` all 0. Because `irq_prev` resets to 0, a line held high through reset registers one edge after release.
- Edge capture: `pending[i]` is set on any edge where `irq_in[i]` & ~`irq_prev[i]`. A second edge on an already-pending line is merged and not counted.
- `eligible` = `pending` & ~mask.
- FSM states: IDLE, REQ, SERVICE.
- IDLE: if `int_en` and `eligible` != 0, load `irq_id` with the highest set index of `eligible`, clear the counter, and go to REQ.
- REQ:
  - `irq_req` = 1. `irq_id` is frozen; a higher-priority arrival does not preempt.
  - On `irq_ack`: clear `pending[irq_id]` and go to SERVICE.
  - Else if `int_en` = 0: go to IDLE; pending is kept.
  - Else if counter = ACK_TIMEOUT-1: set `timeout_err`, go to IDLE; pending is kept.
  - Else the counter increments.
- SERVICE: `data_select` = 1 and `in_service` = 1. `eoi` returns to IDLE. `int_en` is ignored in this state.
- `irq_ack` outside REQ is ignored. `eoi` outside SERVICE is ignored.
- Mask writes take effect on the next edge. Masking `irq_id` during REQ does not withdraw the request.
- Simultaneous clear (ack) and set (new edge) on the same pending bit: set wins.
- `clr_err` and a timeout on the same edge: set wins.
- All outputs are registered.

## Timing
- `irq_in` edge sampled at edge k → `pending` high after k.
- `irq_req` and `irq_id` valid after k+1, if the FSM was in IDLE.
- `irq_ack` sampled at edge m → `irq_req` low and `data_select`/`in_service` high after m.
- `eoi` sampled at edge e → `data_select` low after e. The earliest next `irq_req` is after e+1 (IDLE lasts at least one cycle).
- Without an ack, `irq_req` stays high for exactly ACK_TIMEOUT cycles.
- `rstN` low at any point forces the reset values immediately (asynchronous), including mid-REQ and mid-SERVICE; any transaction in flight is lost.

## Test plan
- Reset with `irq_in`=8'h00, `int_en`=1, then pulse `irq_in[2]` → `pending`=8'h04 one cycle later, then `irq_req`=1 with `irq_id`=2. Ack → `pending`=0, `data_select`=1. `eoi` → `data_select`=0.
- Rising edges on lines 0, 5 and 7 in the same cycle → `irq_id`=7 first. After ack/eoi → `irq_id`=5, then 0. Each ack clears only its own bit.
- Mask 8'h80 with lines 7 and 3 pending → `irq_id`=3. Write mask 8'h00 during REQ → `irq_id` stays 3; line 7 is offered next.
- No ack with ACK_TIMEOUT=15 → `irq_req` high for exactly 15 cycles, then `timeout_err`=1 and `pending` unchanged. `clr_err` → `timeout_err`=0.
- `int_en`=0 with pending 8'h10 → `irq_req` stays 0. Drop `int_en` during REQ → back to IDLE next edge, pending kept. `eoi` while in IDLE → no effect.
- Assert `rstN`=0 mid-SERVICE → `data_select`, `in_service` and `pending` read 0 immediately. Hold `irq_in[1]` high through reset → `pending`=8'h02 one cycle after release.
